// File: rtl/item_spawner_if.sv
// rtl/item_spawner_if.sv - shared tile-map port between the item spawner and the map arbiter
interface item_spawner_if #(
    parameter int ADDR_W = 9
) ();
    logic              req;
    logic              gnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;

    modport master (
        output req, rd_addr, wr_addr, wr_data, wr_en,
        input  gnt, rd_data
    );

    modport slave (
        input  req, rd_addr, wr_addr, wr_data, wr_en,
        output gnt, rd_data
    );
endinterface

// File: rtl/item_spawner.sv
// rtl/item_spawner.sv - periodically places player-owned items on free tiles of the map
module item_spawner #(
    parameter int         COLS         = 20,
    parameter int         ROWS         = 15,
    parameter int         ADDR_W       = 9,
    parameter int         SPAWN_FRAMES = 180,
    parameter int         MAX_ITEMS    = 4,
    parameter int         MAX_TRIES    = 8,
    parameter logic [7:0] EMPTY_ID     = 8'h00
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           frame_clk,
    input  logic           enable,
    input  logic [3:0]     randhex,
    input  logic           item_taken,
    item_spawner_if.master map,
    output logic [2:0]     item_count,
    output logic           busy
);

    localparam int FRM_W = $clog2(SPAWN_FRAMES + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_PICK,
        S_READ,
        S_RDWAIT,
        S_CHECK,
        S_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [TRY_W-1:0]  try_cnt_q, try_cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        id_q, id_d;
    logic [2:0]        count_q, count_d;
    logic              frm_s1_q, frm_s1_d;
    logic              frm_s2_q, frm_s2_d;

    logic              frame_edge;
    logic              write_fire;
    logic [4:0]        pick_x;
    logic [3:0]        pick_y;
    logic              pick_bad;
    logic [TRY_W-1:0]  try_inc;
    logic              tries_done;
    logic              unused_randhex;

    assign unused_randhex = ^randhex[3:1];

    assign frame_edge = frm_s1_q & ~frm_s2_q;
    assign write_fire = (state_q == S_WRITE) && map.gnt;
    assign pick_x     = lfsr_q[4:0];
    assign pick_y     = lfsr_q[12:9];
    assign pick_bad   = (32'(pick_x) >= COLS) || (32'(pick_y) >= ROWS);
    assign try_inc    = try_cnt_q + TRY_W'(1);
    assign tries_done = (try_inc == TRY_W'(MAX_TRIES));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_WAIT;
            frame_cnt_q <= '0;
            try_cnt_q   <= '0;
            lfsr_q      <= 16'hACE1;
            addr_q      <= '0;
            id_q        <= '0;
            count_q     <= '0;
            frm_s1_q    <= 1'b0;
            frm_s2_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            try_cnt_q   <= try_cnt_d;
            lfsr_q      <= lfsr_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            count_q     <= count_d;
            frm_s1_q    <= frm_s1_d;
            frm_s2_q    <= frm_s2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        try_cnt_d   = try_cnt_q;
        addr_d      = addr_q;
        id_d        = id_q;
        frm_s1_d    = frame_clk;
        frm_s2_d    = frm_s1_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        // A simultaneous spawn and pickup cancel out; otherwise saturate at both ends.
        count_d = count_q;
        if (write_fire && !item_taken && (count_q < 3'(MAX_ITEMS))) begin
            count_d = count_q + 3'd1;
        end else if (item_taken && !write_fire && (count_q != 3'd0)) begin
            count_d = count_q - 3'd1;
        end

        case (state_q)
            S_WAIT: begin
                if (!enable) begin
                    frame_cnt_d = '0;
                end else if (frame_edge) begin
                    if (frame_cnt_q == FRM_W'(SPAWN_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        if (count_q < 3'(MAX_ITEMS)) begin
                            state_d   = S_PICK;
                            try_cnt_d = '0;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FRM_W'(1);
                    end
                end
            end
            S_PICK: begin
                if (pick_bad) begin
                    try_cnt_d = try_inc;
                    if (tries_done) begin
                        state_d = S_WAIT;
                    end
                end else begin
                    addr_d  = ADDR_W'(32'(pick_y) * COLS + 32'(pick_x));
                    id_d    = {4'h9, 3'b000, randhex[0]};
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (map.gnt) begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (map.rd_data == EMPTY_ID) begin
                    state_d = S_WRITE;
                end else begin
                    try_cnt_d = try_inc;
                    state_d   = tries_done ? S_WAIT : S_PICK;
                end
            end
            S_WRITE: begin
                if (map.gnt) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // Outputs are decoded from the state alone, apart from wr_en which follows gnt in WRITE.
    always_comb begin
        map.req     = 1'b0;
        map.rd_addr = '0;
        map.wr_addr = '0;
        map.wr_data = '0;
        map.wr_en   = 1'b0;
        case (state_q)
            S_READ, S_RDWAIT, S_CHECK: begin
                map.req     = 1'b1;
                map.rd_addr = addr_q;
            end
            S_WRITE: begin
                map.req     = 1'b1;
                map.wr_addr = addr_q;
                map.wr_data = id_q;
                map.wr_en   = map.gnt;
            end
            default: begin
                map.req = 1'b0;
            end
        endcase
    end

    assign busy       = (state_q != S_WAIT);
    assign item_count = count_q;

endmodule

// File: tb/tb_item_spawner.sv
// tb/tb_item_spawner.sv - scoreboard bench for item_spawner with a short spawn interval
module tb_item_spawner;

    localparam int ADDR_W = 9;
    localparam int NTILES = 300;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       enable;
    logic [3:0] randhex;
    logic       item_taken;
    logic [2:0] item_count;
    logic       busy;

    item_spawner_if #(.ADDR_W(ADDR_W)) m ();

    item_spawner #(
        .COLS(20), .ROWS(15), .ADDR_W(ADDR_W), .SPAWN_FRAMES(4),
        .MAX_ITEMS(4), .MAX_TRIES(8), .EMPTY_ID(8'h00)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .enable(enable),
        .randhex(randhex),
        .item_taken(item_taken),
        .map(m.master),
        .item_count(item_count),
        .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    int req_cycles  = 0;
    int pick_cycles = 0;
    logic [ADDR_W-1:0] last_rd_addr = '0;
    logic req_prev   = 1'b0;
    logic wr_en_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected item id whenever the DUT strobes a write.
    always @(negedge Clk) begin
        if (m.req && !req_prev) last_rd_addr = m.rd_addr;
        if (m.req) req_cycles++;
        if (busy && !m.req) pick_cycles++;
        if (m.wr_en) begin
            check("wr_en_with_req", m.req, 1);
            check("wr_en_single_cycle", wr_en_prev, 0);
            check("wr_addr_in_map", m.wr_addr < NTILES, 1);
            check("wr_addr_eq_rd_addr", m.wr_addr, last_rd_addr);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got wr_data %0h expected no write", m.wr_data);
            end else begin
                check("wr_data", m.wr_data, exp_q.pop_front());
            end
        end
        req_prev   = m.req;
        wr_en_prev = m.wr_en;
    end

    task automatic frame_rise();
        @(posedge Clk) #1 frame_clk = 1'b1;
        @(posedge Clk) #1 frame_clk = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        repeat (3) @(negedge Clk);
        k = 0;
        while (busy && k < 300) begin
            @(negedge Clk);
            k++;
        end
        if (busy) check("wait_idle_timeout", busy, 0);
    endtask

    task automatic wait_req_rise();
        int k;
        k = 0;
        @(negedge Clk);
        while (!m.req && k < 300) begin
            @(negedge Clk);
            k++;
        end
        if (!m.req) check("wait_req_timeout", m.req, 1);
    endtask

    task automatic edges(input int n, input bit push, input logic [7:0] id);
        for (int i = 0; i < n; i++) begin
            if (push && i == n - 1) exp_q.push_back(id);
            frame_rise();
            wait_idle();
        end
    endtask

    task automatic take_item();
        @(posedge Clk) #1 item_taken = 1'b1;
        @(posedge Clk) #1 item_taken = 1'b0;
    endtask

    // Starts an attempt, stalls gnt once WRITE is reached, then releases it.
    task automatic stall_write(input logic [7:0] id, input bit take);
        logic [ADDR_W-1:0] a0;
        logic [7:0]        d0;
        exp_q.push_back(id);
        frame_rise();
        wait_req_rise();
        @(posedge Clk) #1 m.gnt = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        a0 = '0;
        d0 = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                a0 = m.wr_addr;
                d0 = m.wr_data;
            end
            check("stall_wr_en", m.wr_en, 0);
            check("stall_req", m.req, 1);
            check("stall_wr_addr", m.wr_addr, a0);
            check("stall_wr_data", m.wr_data, d0);
        end
        @(posedge Clk) #1;
        m.gnt      = 1'b1;
        item_taken = take;
        @(posedge Clk) #1 item_taken = 1'b0;
        wait_idle();
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; enable = 1'b0; randhex = 4'h1;
        item_taken = 1'b0; m.gnt = 1'b1; m.rd_data = 8'h01;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_req", m.req, 0);
        check("rst_wr_en", m.wr_en, 0);
        check("rst_rd_addr", m.rd_addr, 0);
        check("rst_wr_addr", m.wr_addr, 0);
        check("rst_wr_data", m.wr_data, 0);
        check("rst_item_count", item_count, 0);
        check("rst_busy", busy, 0);
        @(posedge Clk) #1 Reset = 1'b0;
        enable = 1'b1;

        // Occupied tiles: the attempt gives up after 8 candidates.
        edges(3, 0, 8'h00);
        pick_cycles = 0;
        edges(1, 0, 8'h00);
        check("occupied_candidates", pick_cycles, 8);
        check("occupied_count", item_count, 0);
        check("occupied_idle", busy, 0);

        // Free tiles: one spawn on the 4th edge, none before.
        m.rd_data = 8'h00;
        req_cycles = 0;
        edges(3, 0, 8'h00);
        check("no_req_before_4th", req_cycles, 0);
        edges(1, 1, 8'h91);
        check("spawn1_count", item_count, 1);
        check("spawn1_idle", busy, 0);

        // gnt withheld during WRITE.
        randhex = 4'h0;
        edges(3, 0, 8'h00);
        stall_write(8'h90, 0);
        check("stall_count", item_count, 2);

        // Fill to the cap, confirm no attempt, then free one slot.
        randhex = 4'h1;
        edges(4, 1, 8'h91);
        edges(4, 1, 8'h91);
        check("full_count", item_count, 4);
        req_cycles = 0;
        edges(4, 0, 8'h00);
        check("full_no_req", req_cycles, 0);
        check("full_count_hold", item_count, 4);
        take_item();
        @(negedge Clk);
        check("take_from_full", item_count, 3);
        edges(4, 1, 8'h91);
        check("respawn_count", item_count, 4);

        // Simultaneous write and pickup, and pickup at zero.
        take_item();
        take_item();
        @(negedge Clk);
        check("count_before_simul", item_count, 2);
        edges(3, 0, 8'h00);
        stall_write(8'h91, 1);
        check("simul_count", item_count, 2);
        take_item();
        take_item();
        take_item();
        @(negedge Clk);
        check("take_at_zero", item_count, 0);

        // Reset while waiting on read data.
        edges(3, 0, 8'h00);
        frame_rise();
        wait_req_rise();
        @(posedge Clk) #1 Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("rrst_req", m.req, 0);
        check("rrst_wr_en", m.wr_en, 0);
        check("rrst_count", item_count, 0);
        check("rrst_busy", busy, 0);
        @(posedge Clk) #1 Reset = 1'b0;
        req_cycles = 0;
        edges(3, 0, 8'h00);
        check("rrst_no_req", req_cycles, 0);
        edges(1, 1, 8'h91);
        check("rrst_spawn_count", item_count, 1);

        repeat (4) @(negedge Clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
